wb_chip_id_reader: RTL and testbench

- Wishbone (FASM dual-port model) peripheral that drives the device's serial unique-chip-ID primitive directly, through a clock-divided load/shift sequence, with no vendor wrapper IP.
- Captures an ID of parametrised width and exposes it as a DATA_WIDTH-wide read stream plus a control/status register.
- Sits on the MCU peripheral bus beside other CSR blocks; firmware reads it for board serialisation and licence checks.

---
 rtl/chip_id_pkg.sv | 25 ++
 rtl/wb_chip_id_reader_if.sv | 35 +++
 rtl/chip_id_serial_rx.sv | 104 ++++++++++
 rtl/wb_chip_id_reader.sv | 133 +++++++++++++
 tb/tb_wb_chip_id_reader.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/chip_id_pkg.sv
// Shared types and constants for the Wishbone chip-ID reader.
// Holds the capture FSM states, CSR bit layout and timing helper.
package chip_id_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } rx_state_e;

  localparam int CSR_VALID  = 7;
  localparam int CSR_BUSY   = 6;
  localparam int CSR_EMPTY  = 5;
  localparam int CSR_START  = 0;
  localparam int CSR_REWIND = 1;

  function automatic int capture_latency(
    input int id_width,
    input int clk_div
  );
    return (id_width + 1) * 2 * clk_div + 1;
  endfunction

endpackage

// File: rtl/wb_chip_id_reader_if.sv
// FASM-style Wishbone bus bundle for the chip-ID reader.
// Separate read and write address ports, ack follows strobe.
interface wb_chip_id_reader_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  stb_i;
  logic                  we_i;
  logic [DATA_WIDTH-1:0] adr_wr_i;
  logic [DATA_WIDTH-1:0] adr_rd_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  ack_o;

  modport master (
    output stb_i,
    output we_i,
    output adr_wr_i,
    output adr_rd_i,
    output dat_i,
    input  dat_o,
    input  ack_o
  );

  modport slave (
    input  stb_i,
    input  we_i,
    input  adr_wr_i,
    input  adr_rd_i,
    input  dat_i,
    output dat_o,
    output ack_o
  );

endinterface

// File: rtl/chip_id_serial_rx.sv
// Drives the serial chip-ID primitive: divided clock, load pulse,
// then LSB-first shift of ID_WIDTH bits into a local register.
module chip_id_serial_rx
  import chip_id_pkg::*;
#(
  parameter int ID_WIDTH = 64,
  parameter int CLK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [ID_WIDTH-1:0] id_o,
  output logic                id_clk,
  output logic                id_shiftnld,
  input  logic                id_regout
);

  localparam int CW   = $clog2(ID_WIDTH + 1);
  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(ID_WIDTH);

  rx_state_e           state_q, state_d;
  logic [DIVW-1:0]     div_q, div_d;
  logic                id_clk_q, id_clk_d;
  logic                shnld_q, shnld_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ID_WIDTH-1:0] sr_q, sr_d;
  logic                tick;

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      id_clk_q <= 1'b0;
      shnld_q  <= 1'b1;
      cnt_q    <= '0;
      sr_q     <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      id_clk_q <= id_clk_d;
      shnld_q  <= shnld_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    id_clk_d = id_clk_q;
    shnld_d  = shnld_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_LOAD;
          div_d    = '0;
          id_clk_d = 1'b0;
          shnld_d  = 1'b0;
          cnt_d    = '0;
        end
      end
      ST_LOAD: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          id_clk_d = ~id_clk_q;
          // Falling edge closes the single load period.
          if (id_clk_q) begin
            state_d = ST_SHIFT;
            shnld_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          id_clk_d = ~id_clk_q;
          if (!id_clk_q) begin
            sr_d  = {id_regout, sr_q[ID_WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign id_o        = sr_q;
  assign id_clk      = id_clk_q;
  assign id_shiftnld = shnld_q;

endmodule

// File: rtl/wb_chip_id_reader.sv
// Wishbone peripheral exposing the unique chip ID as a word stream
// plus a control/status register; capture is done by chip_id_serial_rx.
module wb_chip_id_reader
  import chip_id_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ID_WIDTH      = 64,
  parameter int CLK_DIV       = 2,
  parameter int REG_ADDR_DATA = 0,
  parameter int REG_ADDR_CSR  = 1,
  parameter bit MSB_FIRST     = 1'b1,
  parameter bit AUTO_START    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  wb_chip_id_reader_if.slave bus,
  output logic               id_clk,
  output logic               id_shiftnld,
  input  logic               id_regout
);

  localparam int NW = ID_WIDTH / DATA_WIDTH;
  localparam int PW = $clog2(NW + 1);
  localparam logic [DATA_WIDTH-1:0] A_DATA = DATA_WIDTH'(REG_ADDR_DATA);
  localparam logic [DATA_WIDTH-1:0] A_CSR  = DATA_WIDTH'(REG_ADDR_CSR);
  localparam logic [PW-1:0]         P_END  = PW'(NW);

  logic                  wr_csr_q, wstart_q, wrew_q, auto_q;
  logic                  valid_q, valid_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]   snap_q, snap_d;
  logic                  busy, done, start, rewind, empty, rd_adv;
  logic [ID_WIDTH-1:0]   id;
  logic [DATA_WIDTH-1:0] word, dat;
  logic [7:0]            csr;
  int                    rem;
  logic                  unused_dat;

  assign unused_dat = ^bus.dat_i[DATA_WIDTH-1:2];

  chip_id_serial_rx #(
    .ID_WIDTH (ID_WIDTH),
    .CLK_DIV  (CLK_DIV)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start),
    .busy_o      (busy),
    .done_o      (done),
    .id_o        (id),
    .id_clk      (id_clk),
    .id_shiftnld (id_shiftnld),
    .id_regout   (id_regout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_csr_q <= 1'b0;
      wstart_q <= 1'b0;
      wrew_q   <= 1'b0;
      auto_q   <= AUTO_START;
      valid_q  <= 1'b0;
      ptr_q    <= '0;
      snap_q   <= '0;
    end else begin
      wr_csr_q <= bus.stb_i & bus.we_i & (bus.adr_wr_i == A_CSR);
      wstart_q <= bus.dat_i[CSR_START];
      wrew_q   <= bus.dat_i[CSR_REWIND];
      auto_q   <= 1'b0;
      valid_q  <= valid_d;
      ptr_q    <= ptr_d;
      snap_q   <= snap_d;
    end
  end

  assign start  = (auto_q | (wr_csr_q & wstart_q)) & ~busy;
  assign rewind = wr_csr_q & wrew_q & ~wstart_q & ~busy;
  assign empty  = valid_q & (ptr_q == P_END);
  assign rd_adv = bus.stb_i & ~bus.we_i & (bus.adr_rd_i == A_DATA)
                & valid_q & ~empty;

  // A rewind write outranks a same-cycle stream read.
  always_comb begin
    valid_d = valid_q;
    ptr_d   = ptr_q;
    snap_d  = snap_q;
    if (done) begin
      valid_d = 1'b1;
      ptr_d   = '0;
      snap_d  = id;
    end else if (start) begin
      valid_d = 1'b0;
    end else if (rewind) begin
      ptr_d = '0;
    end else if (rd_adv) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_comb begin
    word = '0;
    for (int i = 0; i < NW; i++) begin
      if (PW'(MSB_FIRST ? NW - 1 - i : i) == ptr_q) begin
        word = snap_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rem = valid_q ? NW - int'(ptr_q) : 0;
    if (rem > 31) rem = 31;
    csr            = '0;
    csr[CSR_VALID] = valid_q;
    csr[CSR_BUSY]  = busy;
    csr[CSR_EMPTY] = empty;
    csr[4:0]       = 5'(rem);
  end

  always_comb begin
    dat = '0;
    unique case (1'b1)
      (bus.adr_rd_i == A_DATA): begin
        if (valid_q && !empty) dat = word;
      end
      (bus.adr_rd_i == A_CSR): dat = DATA_WIDTH'(csr);
      default: ;
    endcase
  end

  assign bus.dat_o = dat;
  assign bus.ack_o = bus.stb_i;

endmodule

// File: tb/tb_wb_chip_id_reader.sv
// Bench for wb_chip_id_reader: two instances (64-bit MSB-first, 128-bit
// LSB-first) fed by behavioural chip-ID primitives.
module tb_wb_chip_id_reader;

  localparam int W0   = 64;
  localparam int C0   = 2;
  localparam int W1   = 128;
  localparam int C1   = 1;
  localparam int LAT0 = (W0 + 1) * 2 * C0 + 1;
  localparam int LAT1 = (W1 + 1) * 2 * C1 + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wb_chip_id_reader_if #(.DATA_WIDTH(8)) b0 ();
  wb_chip_id_reader_if #(.DATA_WIDTH(8)) b1 ();

  logic ck0, sn0, rg0, ck1, sn1, rg1;
  logic [W0-1:0] id0;
  logic [W1-1:0] id1;
  logic [W0-1:0] prim0 = '0;
  logic [W1-1:0] prim1 = '0;

  // Primitive: parallel load when shiftnld=0, else shift toward bit 0.
  always @(posedge ck0) prim0 <= sn0 ? (prim0 >> 1) : id0;
  always @(posedge ck1) prim1 <= sn1 ? (prim1 >> 1) : id1;
  assign rg0 = prim0[0];
  assign rg1 = prim1[0];

  wb_chip_id_reader #(
    .DATA_WIDTH (8),
    .ID_WIDTH   (W0),
    .CLK_DIV    (C0),
    .MSB_FIRST  (1'b1),
    .AUTO_START (1'b1)
  ) u0 (
    .clk         (clk),
    .reset       (reset),
    .bus         (b0),
    .id_clk      (ck0),
    .id_shiftnld (sn0),
    .id_regout   (rg0)
  );

  wb_chip_id_reader #(
    .DATA_WIDTH (8),
    .ID_WIDTH   (W1),
    .CLK_DIV    (C1),
    .MSB_FIRST  (1'b0),
    .AUTO_START (1'b1)
  ) u1 (
    .clk         (clk),
    .reset       (reset),
    .bus         (b1),
    .id_clk      (ck1),
    .id_shiftnld (sn1),
    .id_regout   (rg1)
  );

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd0(input logic [7:0] a, output logic [7:0] d);
    b0.stb_i = 1'b1; b0.we_i = 1'b0; b0.adr_rd_i = a;
    #1 d = b0.dat_o;
    @(posedge clk); #1;
    b0.stb_i = 1'b0; b0.adr_rd_i = 8'd1;
  endtask

  task automatic rd1(input logic [7:0] a, output logic [7:0] d);
    b1.stb_i = 1'b1; b1.we_i = 1'b0; b1.adr_rd_i = a;
    #1 d = b1.dat_o;
    @(posedge clk); #1;
    b1.stb_i = 1'b0; b1.adr_rd_i = 8'd1;
  endtask

  task automatic wr0(input logic [7:0] a, input logic [7:0] v);
    b0.stb_i = 1'b1; b0.we_i = 1'b1; b0.adr_wr_i = a; b0.dat_i = v;
    @(posedge clk); #1;
    b0.stb_i = 1'b0; b0.we_i = 1'b0; b0.dat_i = '0;
  endtask

  task automatic wait_valid0(output int lat);
    lat = -1;
    for (int n = 1; n <= 2000 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (b0.dat_o[7]) lat = n;
    end
  endtask

  initial begin
    int lat0, lat1;
    logic [7:0] d;

    id0 = 64'h0123_4567_89AB_CDEF;
    id1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    b0.stb_i = 1'b0; b0.we_i = 1'b0; b0.adr_wr_i = '0;
    b0.adr_rd_i = 8'd1; b0.dat_i = '0;
    b1.stb_i = 1'b0; b1.we_i = 1'b0; b1.adr_wr_i = '0;
    b1.adr_rd_i = 8'd1; b1.dat_i = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_idclk", ck0, 1'b0);
    chk("rst_shnld", sn0, 1'b1);
    chk("rst_csr0", b0.dat_o, 8'h00);

    // First edge with reset low accepts the automatic start.
    reset = 1'b0;
    @(posedge clk); #1;
    chk("auto_busy0", b0.dat_o, 8'h40);
    chk("auto_busy1", b1.dat_o, 8'h40);

    lat0 = -1;
    lat1 = -1;
    for (int n = 1; n <= 2000 && (lat0 < 0 || lat1 < 0); n++) begin
      @(posedge clk); #1;
      if (lat0 < 0 && b0.dat_o[7]) lat0 = n;
      if (lat1 < 0 && b1.dat_o[7]) lat1 = n;
      if (n == 50) begin
        b0.stb_i = 1'b1; b0.we_i = 1'b1;
        b0.adr_wr_i = 8'd1; b0.dat_i = 8'h01;
      end
      if (n == 51) begin
        b0.stb_i = 1'b0; b0.we_i = 1'b0; b0.dat_i = '0;
      end
      if (n == 80) begin
        b0.stb_i = 1'b1; b0.adr_rd_i = 8'd0;
        #1 chk("busy_data0", b0.dat_o, 8'h00);
        b0.adr_rd_i = 8'd1;
        #1 chk("busy_csr0", b0.dat_o, 8'h40);
        b0.stb_i = 1'b0;
      end
    end
    chk("lat0", lat0, LAT0);
    chk("lat1", lat1, LAT1);
    chk("idle_idclk", ck0, 1'b0);
    chk("idle_shnld", sn0, 1'b1);
    chk("csr0_full", b0.dat_o, 8'h88);

    for (int k = 0; k < W0 / 8; k++) begin
      rd0(8'd0, d);
      chk("data0", d, id0[W0-1-8*k -: 8]);
    end
    rd0(8'd0, d);
    chk("data0_empty", d, 8'h00);
    rd0(8'd1, d);
    chk("csr0_empty", d, 8'hA0);

    wr0(8'd1, 8'h02);
    @(posedge clk); #1;
    chk("csr0_rewind", b0.dat_o, 8'h88);
    rd0(8'd0, d);
    chk("data0_rewind", d, id0[W0-1 -: 8]);

    for (int k = 0; k < W1 / 8; k++) begin
      rd1(8'd1, d);
      chk("csr1_count", d, 8'h80 | (W1 / 8 - k));
      rd1(8'd0, d);
      chk("data1", d, id1[8*k +: 8]);
    end
    rd1(8'd1, d);
    chk("csr1_empty", d, 8'hA0);
    rd1(8'd0, d);
    chk("data1_empty", d, 8'h00);

    wr0(8'd1, 8'h01);
    @(posedge clk); #1;
    chk("restart_busy", b0.dat_o, 8'h40);
    repeat (99) @(posedge clk);
    id0 = {$urandom(), $urandom()};
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_idclk", ck0, 1'b0);
    chk("mid_shnld", sn0, 1'b1);
    chk("mid_csr0", b0.dat_o, 8'h00);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("re_busy0", b0.dat_o, 8'h40);
    wait_valid0(lat0);
    chk("re_lat0", lat0, LAT0);
    for (int k = 0; k < W0 / 8; k++) begin
      rd0(8'd0, d);
      chk("re_data0", d, id0[W0-1-8*k -: 8]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
